// File: rtl/mem_initiator_if.sv
// mem_initiator_if
//   Single-port data memory bus between the load/store initiator and the
//   memory block.
//
//   Signals:
//     mem_w      initiator -> memory   write strobe (one cycle per write)
//     mem_addr   initiator -> memory   word address, held between requests
//     mem_wdata  initiator -> memory   write data
//     mem_rdata  memory -> initiator   read data (echoes data after a write)
//     mem_ready  memory -> initiator   memory has settled, mem_rdata is valid
//
//   Modports:
//     master  the initiator side (drives strobe, address and write data)
//     slave   the memory side (drives read data and ready)

interface mem_initiator_if;
    logic        mem_w;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_w,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_w,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_initiator.sv
// mem_initiator
//   Bus-master front end for the single-port data memory. Takes one read or
//   write request at a time from the stack-processor load/store logic,
//   drives a one-cycle write strobe followed by a settle cycle, polls memory
//   ready and returns the read data (or the write echo) with an error flag.
//
//   Parameters:
//     ADDR_LIMIT  first invalid word address; such requests fail immediately
//                 without touching the memory bus
//     TIMEOUT     maximum number of WAIT cycles before aborting (1..255)
//
//   Ports:
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     req_valid   request present
//     req_write   1 = write, 0 = read
//     req_addr    word address
//     req_wdata   write data
//     req_ready   block can accept a request this cycle (IDLE or RESP)
//     resp_valid  one-cycle pulse, response complete
//     resp_rdata  read data or write echo (0 on error)
//     resp_err    out-of-range or timeout, valid with resp_valid
//     mem         memory bus, master side

module mem_initiator #(
    parameter logic [15:0] ADDR_LIMIT = 16'h0100,
    parameter int          TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    input  logic              req_write,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              req_ready,

    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,

    mem_initiator_if.master   mem
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic        last_valid;
    logic [7:0]  wait_cnt;
    logic        accept;

    // req_ready is registered and is only high in IDLE and RESP, so a
    // request is taken exactly when both sides agree at a clock edge.
    assign accept = req_valid && req_ready;

    // Single registered FSM. last_valid records that mem_addr currently
    // points at a location the memory has settled on; a read to that same
    // address can skip the strobe/settle cycles because the memory's
    // address-change detector will not drop ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= 16'h0000;
            resp_err      <= 1'b0;
            mem.mem_w     <= 1'b0;
            mem.mem_addr  <= 16'h0000;
            mem.mem_wdata <= 16'h0000;
            last_valid    <= 1'b0;
            wait_cnt      <= 8'h00;
        end else begin
            resp_valid <= 1'b0;

            case (state)
                // RESP accepts exactly like IDLE so transfers can run
                // back to back without an idle cycle in between.
                IDLE, RESP: begin
                    if (accept) begin
                        if (req_addr >= ADDR_LIMIT) begin
                            // Fail without disturbing the memory bus.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 16'h0000;
                            req_ready  <= 1'b1;
                        end else begin
                            mem.mem_addr  <= req_addr;
                            mem.mem_wdata <= req_wdata;
                            mem.mem_w     <= req_write;
                            req_ready     <= 1'b0;
                            if (!req_write && last_valid && (req_addr == mem.mem_addr)) begin
                                state    <= WAIT;
                                wait_cnt <= 8'h00;
                            end else begin
                                state <= ISSUE;
                            end
                        end
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end

                // Strobe has been high for exactly this one cycle.
                ISSUE: begin
                    mem.mem_w <= 1'b0;
                    state     <= SETTLE;
                end

                // Ready is stale or falling here, so it is not looked at.
                SETTLE: begin
                    state    <= WAIT;
                    wait_cnt <= 8'h00;
                end

                // Poll ready; give up after TIMEOUT consecutive not-ready
                // cycles. A timeout leaves the memory state unknown, so the
                // same-address shortcut is disabled until the next success.
                WAIT: begin
                    if (mem.mem_ready) begin
                        resp_rdata <= mem.mem_rdata;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        last_valid <= 1'b1;
                        req_ready  <= 1'b1;
                        state      <= RESP;
                    end else if ((wait_cnt + 8'd1) == TIMEOUT_CNT) begin
                        resp_rdata <= 16'h0000;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        last_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator
//   Self-checking bench for mem_initiator. A behavioural memory stub with a
//   configurable settle delay sits on the bus; a transaction-level reference
//   model predicts latency, response data, error flag, strobe count and the
//   bus address for each request.

module tb_mem_initiator;

    localparam logic [15:0] LIMIT = 16'h0100;
    localparam int          TMO   = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    mem_initiator_if mem_bus ();

    mem_initiator #(
        .ADDR_LIMIT (LIMIT),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem        (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stub: ready drops for mem_delay cycles whenever it sees a write
    // strobe or an address change; read data echoes the addressed word.
    logic [15:0] stub_mem [0:255];
    logic [15:0] seen_addr;
    int          busy;
    int          mem_delay = 1;
    bit          stall_mem = 1'b0;
    bit          stub_loaded = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!stub_loaded) begin
                for (int i = 0; i < 256; i++) stub_mem[i] <= 16'(i * 257) ^ 16'h5A5A;
                stub_loaded <= 1'b1;
            end
            seen_addr <= 16'h0000;
            busy      <= 0;
        end else begin
            if (mem_bus.mem_w) stub_mem[mem_bus.mem_addr[7:0]] <= mem_bus.mem_wdata;
            if (mem_bus.mem_w || (mem_bus.mem_addr != seen_addr)) begin
                seen_addr <= mem_bus.mem_addr;
                busy      <= mem_delay;
            end else if (busy != 0) begin
                busy <= busy - 1;
            end
        end
    end

    assign mem_bus.mem_rdata = stub_mem[mem_bus.mem_addr[7:0]];
    assign mem_bus.mem_ready = !stall_mem && (busy == 0);

    // Monitors, sampled on the falling edge.
    int strobe_count = 0;
    int resp_count   = 0;
    always @(negedge clk) begin
        if (mem_bus.mem_w) strobe_count <= strobe_count + 1;
        if (resp_valid)    resp_count   <= resp_count + 1;
    end

    // Reference model state.
    logic [15:0] ref_mem [0:255];
    bit          ref_last_valid;
    logic [15:0] ref_bus_addr;

    int assert_count = 0;
    int fail_count   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one request at the current falling edge and wait for its
    // response. Returns at the falling edge of the RESP cycle; lat counts
    // cycles from the accept edge, the RESP cycle being number lat.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                                 input bit hold_valid, output int lat,
                                 output logic [15:0] rdata, output logic err);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        checkOutput("req_ready_on_issue", {31'd0, req_ready}, 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold_valid) req_valid = 1'b0;
            if (!resp_valid) checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
        end while (!resp_valid && lat < 40);
        rdata     = resp_rdata;
        err       = resp_err;
        req_valid = 1'b0;
    endtask

    task automatic runTransaction(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                                  input bit hold_valid);
        int          exp_lat, exp_strobes, lat, strobes_before;
        logic [15:0] exp_data, exp_bus_addr, rdata;
        logic        exp_err, err;

        if (addr >= LIMIT) begin
            exp_lat      = 1;
            exp_err      = 1'b1;
            exp_data     = 16'h0000;
            exp_bus_addr = ref_bus_addr;
            exp_strobes  = 0;
        end else begin
            exp_err      = 1'b0;
            exp_bus_addr = addr;
            exp_strobes  = wr ? 1 : 0;
            if (!wr && ref_last_valid && addr == ref_bus_addr) exp_lat = 2;
            else if (wr || addr != ref_bus_addr)                exp_lat = 3 + mem_delay;
            else                                                exp_lat = 4;
            if (wr) ref_mem[addr[7:0]] = wdata;
            exp_data       = ref_mem[addr[7:0]];
            ref_last_valid = 1'b1;
            ref_bus_addr   = addr;
        end

        strobes_before = strobe_count;
        applyStimulus(wr, addr, wdata, hold_valid, lat, rdata, err);
        checkOutput("latency",    32'(lat), 32'(exp_lat));
        checkOutput("resp_err",   {31'd0, err}, {31'd0, exp_err});
        checkOutput("resp_rdata", {16'd0, rdata}, {16'd0, exp_data});
        checkOutput("strobes",    32'(strobe_count - strobes_before), 32'(exp_strobes));
        checkOutput("mem_addr",   {16'd0, mem_bus.mem_addr}, {16'd0, exp_bus_addr});
    endtask

    initial begin
        int          lat;
        logic [15:0] rdata;
        logic        err;
        int          resp_before;
        logic [15:0] addr;
        logic        wr;

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
        ref_last_valid = 1'b0;
        ref_bus_addr   = 16'h0000;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_w",      {31'd0, mem_bus.mem_w}, 32'd0);
        checkOutput("rst_mem_addr",   {16'd0, mem_bus.mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata",  {16'd0, mem_bus.mem_wdata}, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
        checkOutput("rst_resp_err",   {31'd0, resp_err}, 32'd0);
        checkOutput("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, read elsewhere, read back.
        mem_delay = 1;
        runTransaction(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        @(negedge clk);
        mem_delay = 2;
        runTransaction(1'b0, 16'h0020, 16'h0000, 1'b0);
        @(negedge clk);
        mem_delay = 1;
        runTransaction(1'b0, 16'h0010, 16'h0000, 1'b0);

        // Back-to-back same-address reads, each accepted in the RESP cycle.
        runTransaction(1'b0, 16'h0010, 16'h0000, 1'b0);
        runTransaction(1'b0, 16'h0010, 16'h0000, 1'b0);
        @(negedge clk);

        // Out-of-range request.
        runTransaction(1'b0, 16'h0100, 16'h0000, 1'b0);
        @(negedge clk);

        // Timeout with memory stuck not-ready, then a same-address retry.
        stall_mem = 1'b1;
        applyStimulus(1'b0, 16'h0030, 16'h0000, 1'b0, lat, rdata, err);
        checkOutput("timeout_latency", 32'(lat), 32'(3 + TMO));
        checkOutput("timeout_err",     {31'd0, err}, 32'd1);
        checkOutput("timeout_rdata",   {16'd0, rdata}, 32'd0);
        ref_last_valid = 1'b0;
        ref_bus_addr   = 16'h0030;
        stall_mem = 1'b0;
        @(negedge clk);
        runTransaction(1'b0, 16'h0030, 16'h0000, 1'b0);
        @(negedge clk);

        // Reset asserted during the SETTLE cycle of a write.
        mem_delay   = 2;
        resp_before = resp_count;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'h1234;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abort_strobe_issue", {31'd0, mem_bus.mem_w}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mem_w",     {31'd0, mem_bus.mem_w}, 32'd0);
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("abort_no_resp",   32'(resp_count - resp_before), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_last_valid = 1'b0;
        ref_bus_addr   = 16'h0000;
        @(negedge clk);
        runTransaction(1'b1, 16'h0040, 16'h4321, 1'b0);
        @(negedge clk);
        runTransaction(1'b0, 16'h0040, 16'h0000, 1'b0);
        @(negedge clk);

        // req_valid held high for the whole transaction.
        resp_before = resp_count;
        mem_delay   = 1;
        runTransaction(1'b1, 16'h0055, 16'hA5C3, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("hold_single_resp", 32'(resp_count - resp_before), 32'd1);
        @(negedge clk);

        // Randomized traffic over a small address pool.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       addr = LIMIT + 16'($urandom_range(0, 16'hFEFF));
                1, 2, 3: addr = ref_bus_addr;
                default: addr = 16'h0010 + 16'($urandom_range(0, 3));
            endcase
            wr        = ($urandom_range(0, 2) == 0);
            mem_delay = $urandom_range(1, 3);
            runTransaction(wr, addr, 16'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus-master front end for the single-port data memory (interface signals: write strobe, address, write data, read data, ready).
- Accepts one read or write request at a time from the stack-processor core and drives the memory protocol: one-cycle write strobe, then a settle cycle.
- Polls memory ready and returns read data, or the write echo, with an error flag.
- Sits between the core's load/store logic and the memory block.

Parameters:
- ADDR_LIMIT, 16'h0100, first invalid address; requests at or above it fail without touching memory.
- TIMEOUT, 16, maximum WAIT cycles before aborting with an error (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_write  input  1  1 = write, 0 = read
- req_addr  input  16  word address
- req_wdata  input  16  write data
- req_ready  output  1  block idle; request accepted when req_valid & req_ready at a clock edge
- resp_valid  output  1  one-cycle pulse, response complete
- resp_rdata  output  16  read data, or write echo from memory
- resp_err  output  1  valid with resp_valid; out-of-range or timeout
- mem_w  output  1  memory write strobe, registered
- mem_addr  output  16  memory address, registered, held between requests
- mem_wdata  output  16  memory write data, registered
- mem_rdata  input  16  memory read data
- mem_ready  input  1  memory ready

Behaviour:
- Reset (async, rst_n=0):
  - outputs: mem_w=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1
  - state IDLE, last_valid=0, timeout counter 0
  - mem_w is forced low immediately, not at the next edge.
  - Reset mid-operation abandons the transaction with no response. An in-flight write may or may not have landed.
- FSM states: IDLE, ISSUE, SETTLE, WAIT, RESP.
- IDLE: req_ready=1.
  - On accept with req_addr >= ADDR_LIMIT: go to RESP with resp_err=1, resp_rdata=0. No mem_* change.
  - Other accepts: load mem_addr=req_addr and mem_wdata=req_wdata; mem_w=req_write.
  - Next state is WAIT if the request is a read with last_valid=1 and req_addr==mem_addr (same-address shortcut: memory does not drop ready).
  - All other valid accepts go to ISSUE.
- ISSUE: lasts exactly one cycle. mem_w clears at exit, so the strobe is exactly 1 cycle. Next state SETTLE.
- SETTLE: lasts exactly one cycle. Memory ready is not sampled here (it is stale or dropping). Next state WAIT.
- WAIT:
  - mem_ready=1: capture mem_rdata into resp_rdata, resp_err=0, set last_valid=1, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: resp_err=1, resp_rdata=0, last_valid=0, go to RESP.
  - The counter clears on WAIT entry.
- RESP: resp_valid=1 for exactly this cycle; req_ready=1 in this same cycle.
  - A request accepted in RESP is handled exactly as in IDLE, enabling back-to-back transfers.
  - Otherwise go to IDLE.
- req_ready=0 in ISSUE, SETTLE and WAIT; req_valid is ignored there. Request inputs are sampled only at accept.
- Writes always take the full path and set last_valid=1. The memory echoes write data, so resp_rdata equals the written value.
- Latency from accept edge to resp_valid high:
  - full path: 4 cycles when memory responds normally
  - shortcut read: 2 cycles
  - out-of-range: 1 cycle
- mem_addr holds its last value through IDLE so the memory's address-change detector does not re-trigger.

Test Plan:
- Write 0x10 <- 16'hBEEF, then read 0x20, then read 0x10.
  - Write: mem_w high exactly 1 cycle, resp_valid 4 cycles after accept, resp_rdata=BEEF, resp_err=0.
  - Read of 0x10 returns BEEF after 4 cycles.
- Read 0x10 twice back-to-back, second accepted in the RESP cycle.
  - Second response after 2 cycles with identical data.
  - No mem_addr change and no mem_w.
- Read 16'h0100 with ADDR_LIMIT=16'h0100: resp_valid next cycle, resp_err=1, resp_rdata=0, mem_* unchanged.
- Memory stub holds mem_ready=0, TIMEOUT=8: resp_err=1 on the cycle after 8 WAIT cycles. A following same-address read takes the full 4-cycle path.
- Assert rst_n=0 during SETTLE of a write: mem_w=0 and req_ready=1 immediately, no resp_valid. The next request completes normally.
- req_valid held high while busy: exactly one accept per transaction; req_ready low in ISSUE, SETTLE and WAIT.
